muldiv_unit_p: RTL and testbench

MULDIV_UNIT_P -- requirements
Module: muldiv_unit_p

---
 rtl/muldiv_unit_p.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit_p.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_p.sv
// Multiply/divide unit holding the architectural HI/LO pair.
//
// Multiply-class ops (MULT/MULTU/MADD/MADDU/MSUB/MSUBU) occupy the unit for
// MUL_LAT cycles and divide-class ops (DIV/DIVU) for DIV_LAT cycles. HI/LO are
// written once, on the edge that ends the last busy cycle. MTHI/MTLO write
// immediately and never raise busy.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-low reset
//   start    - issue op this cycle (taken only when idle and flush=0)
//   op       - 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//              7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, 11-15 NOP
//   a, b     - rs / rt operands
//   flush    - cancel the in-flight op, no write
//   busy     - op in flight
//   hi, lo   - architectural HI / LO
//   div_zero - one-cycle pulse when a divide by zero completes
module muldiv_unit_p #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CW = 6;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e           state, state_n;
    logic [CW-1:0]    cnt;
    logic [3:0]       cop;
    logic [WIDTH-1:0] ca, cb;

    logic is_mul, is_div, accept, last;

    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                 (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
        is_div = (op == OP_DIV) || (op == OP_DIVU);
        accept = (state == S_IDLE) && start && !flush;
        last   = (cnt == CW'(1));
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (accept && (is_mul || is_div)) state_n = S_BUSY;
            S_BUSY: if (flush || last) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign busy = (state == S_BUSY);

    // Result datapath, evaluated from captured operands and current HI/LO.
    logic [2*WIDTH-1:0] prod_s, prod_u, acc, res;
    logic               sdiv, a_neg, b_neg, dz;
    logic [WIDTH-1:0]   abs_a, abs_b, dvs, uq, ur, quo, rem;

    always_comb begin
        prod_s = $signed({{WIDTH{ca[WIDTH-1]}}, ca}) * $signed({{WIDTH{cb[WIDTH-1]}}, cb});
        prod_u = {{WIDTH{1'b0}}, ca} * {{WIDTH{1'b0}}, cb};
        acc    = {hi, lo};

        // One unsigned divider on magnitudes serves both DIV and DIVU.
        // For -2^(W-1) / -1 the magnitude 2^(W-1) negates back onto itself,
        // giving lo=-2^(W-1), hi=0 without a special case.
        sdiv  = (cop == OP_DIV);
        a_neg = sdiv & ca[WIDTH-1];
        b_neg = sdiv & cb[WIDTH-1];
        abs_a = a_neg ? -ca : ca;
        abs_b = b_neg ? -cb : cb;
        dvs   = (abs_b == '0) ? WIDTH'(1) : abs_b;
        uq    = abs_a / dvs;
        ur    = abs_a % dvs;
        quo   = (a_neg ^ b_neg) ? -uq : uq;
        rem   = a_neg ? -ur : ur;
        dz    = ((cop == OP_DIV) || (cop == OP_DIVU)) && (cb == '0);

        res = acc;
        case (cop)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_MADD:  res = acc + prod_s;
            OP_MADDU: res = acc + prod_u;
            OP_MSUB:  res = acc - prod_s;
            OP_MSUBU: res = acc - prod_u;
            OP_DIV,
            OP_DIVU:  res = {rem, quo};
            default:  res = acc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cop      <= '0;
            ca       <= '0;
            cb       <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_n;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end else if (is_mul || is_div) begin
                            cnt <= is_mul ? CW'(MUL_LAT) : CW'(DIV_LAT);
                            cop <= op;
                            ca  <= a;
                            cb  <= b;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        cnt <= '0;
                    end else if (last) begin
                        cnt <= '0;
                        if (dz) div_zero <= 1'b1;
                        else    {hi, lo} <= res;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit_p.sv
// Bench for muldiv_unit_p (WIDTH=32, MUL_LAT=5, DIV_LAT=10). Stimulus pushes
// the expected HI/LO/div_zero and completion cycle into a queue; a monitor
// pops an entry each time busy falls and otherwise checks HI/LO hold.
module tb_muldiv_unit_p;

    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic [3:0]    op = 4'd0;
    logic [W-1:0]  a = '0, b = '0;
    logic          busy, div_zero;
    logic [W-1:0]  hi, lo;

    muldiv_unit_p #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           done;
        bit           chk_cyc;
    } exp_t;

    exp_t         q[$];
    int           n_chk = 0, n_pass = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    endtask

    // Reference model: the architectural effect of one completed op.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] x, y, h, l,
                                  output logic [W-1:0] nh, nl, output logic dz);
        int          sx, sy, sq, sr;
        longint      lx, ly, ps;
        logic [63:0] pu, acc;
        sx = x; sy = y; lx = sx; ly = sy;
        ps  = lx * ly;
        pu  = {32'b0, x} * {32'b0, y};
        acc = {h, l};
        nh = h; nl = l; dz = 1'b0;
        case (o)
            4'd1:  {nh, nl} = ps;
            4'd2:  {nh, nl} = pu;
            4'd7:  {nh, nl} = acc + ps;
            4'd8:  {nh, nl} = acc + pu;
            4'd9:  {nh, nl} = acc - ps;
            4'd10: {nh, nl} = acc - pu;
            4'd3: begin
                if (y == 0) dz = 1'b1;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    nl = x; nh = '0;
                end else begin
                    sq = sx / sy; sr = sx % sy;
                    nl = sq; nh = sr;
                end
            end
            4'd4: begin
                if (y == 0) dz = 1'b1;
                else begin nl = x / y; nh = x % y; end
            end
            4'd5:  nh = x;
            4'd6:  nl = x;
            default: ;
        endcase
    endfunction

    // Monitor
    initial begin
        logic pb;
        exp_t e;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (pb && !busy) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("done_hi", hi, e.hi);
                    check("done_lo", lo, e.lo);
                    check("done_div_zero", div_zero, e.dz);
                    if (e.chk_cyc) check("done_cycle", cyc, e.done);
                end
            end else begin
                check("hold_hi", hi, m_hi);
                check("hold_lo", lo, m_lo);
                check("div_zero_low", div_zero, 0);
            end
            pb = busy;
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, y, output int e);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0; a = $urandom; b = $urandom;
        e = cyc;
    endtask

    // fl < 0: run to completion; fl >= 0: flush fl cycles after issue.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, y, input int fl);
        logic [W-1:0] nh, nl;
        logic         dz;
        int           e, lat;
        bit           mul, dv;
        mul = (o == 1) || (o == 2) || (o >= 7 && o <= 10);
        dv  = (o == 3) || (o == 4);
        lat = mul ? ML : DL;
        model(o, x, y, m_hi, m_lo, nh, nl, dz);
        if (!(mul || dv)) begin
            issue(o, x, y, e);
            check("no_busy", busy, 0);
            m_hi = nh; m_lo = nl;
            return;
        end
        if (fl >= lat) fl = lat - 1;
        issue(o, x, y, e);
        check("busy_rise", busy, 1);
        if (fl >= 0) begin
            q.push_back('{hi: m_hi, lo: m_lo, dz: 1'b0, done: e + fl + 1, chk_cyc: 1'b1});
            for (int i = 0; i < fl; i++) begin @(posedge clk); #1; end
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end else begin
            q.push_back('{hi: nh, lo: nl, dz: dz, done: e + lat, chk_cyc: 1'b1});
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("wait_idle", busy, 0);
        if (fl < 0 && !dz) begin m_hi = nh; m_lo = nl; end
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int e;
        logic [3:0] ro;
        int rf;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_div_zero", div_zero, 0);
        @(negedge clk);
        reset = 1'b1;

        // MULT -2 * 3
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, -1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // DIV / DIVU -7, 2
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, -1);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        run_op(4'd4, 32'hFFFF_FFF9, 32'd2, -1);
        check("divu_lo", lo, 32'h7FFF_FFFC);
        check("divu_hi", hi, 32'd1);

        // MTHI/MTLO then MADDU wrap
        run_op(4'd5, 32'd5, 32'd0, -1);
        run_op(4'd6, 32'd7, 32'd0, -1);
        check("mt_hi", hi, 32'd5);
        check("mt_lo", lo, 32'd7);
        run_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check("maddu_hi", hi, 32'd3);
        check("maddu_lo", lo, 32'd8);

        // Divide by zero leaves HI/LO untouched
        run_op(4'd5, 32'h11, 32'd0, -1);
        run_op(4'd6, 32'h22, 32'd0, -1);
        run_op(4'd3, 32'd1234, 32'd0, -1);
        check("dz_hi", hi, 32'h11);
        check("dz_lo", lo, 32'h22);

        // Signed overflow
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        // NOP and invalid op
        run_op(4'd0, 32'd9, 32'd9, -1);
        run_op(4'd13, 32'd9, 32'd9, -1);

        // MULT, ignored start while busy, flush at T+3
        issue(4'd1, 32'd7, 32'd9, e);
        q.push_back('{hi: m_hi, lo: m_lo, dz: 1'b0, done: e + 3, chk_cyc: 1'b1});
        @(posedge clk); #1;
        start = 1'b1; op = 4'd4; a = 32'd100; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        // start together with flush is dropped
        start = 1'b1; flush = 1'b1; op = 4'd1; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; op = 4'd0;
        check("start_flush_busy", busy, 0);
        @(negedge clk);

        // Flush in the final busy cycle
        run_op(4'd1, 32'd100, 32'd200, ML - 1);
        run_op(4'd4, 32'd100, 32'd7, DL - 1);

        // Randomized ops, some flushed
        for (int n = 0; n < 40; n++) begin
            ro = 4'($urandom_range(1, 10));
            rf = ($urandom_range(0, 4) == 0) ? $urandom_range(0, DL - 1) : -1;
            run_op(ro, rnd_val(), rnd_val(), rf);
        end

        // Reset during DIV at T+2
        issue(4'd3, 32'd100, 32'd7, e);
        q.push_back('{hi: '0, lo: '0, dz: 1'b0, done: 0, chk_cyc: 1'b0});
        @(posedge clk); #1;
        #2;
        reset = 1'b0; m_hi = '0; m_lo = '0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        issue(4'd6, 32'd9, 32'd0, e);
        m_lo = 32'd9;
        check("post_rst_mtlo", lo, 32'd9);
        repeat (15) @(negedge clk);

        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
